// File: rtl/fsk_modem.sv
// fsk_modem: single-clock binary FSK modulator/demodulator.
// The transmitter serialises a WIDTH-bit word MSB first as a square wave:
// period-4 for '1' and period-8 for '0'. The receiver counts rx_in
// transitions per bit window and compares the count against THRESH.
// TX and RX share the bit/frame counters, so both are frame-aligned by reset.
// Optional feature: define FSK_VALID_EN to add the dout_valid strobe output.
module fsk_modem #(
  parameter int WIDTH      = 9,
  parameter int BIT_CYCLES = 16,
  parameter int THRESH     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] datain,
  output logic             fskdata,
  input  logic             rx_in,
  output logic [WIDTH-1:0] dataout
`ifdef FSK_VALID_EN
  ,
  output logic             dout_valid
`endif
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = $clog2(WIDTH);

  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic [IW-1:0]    bit_idx, idx_nxt, tx_sel;
  logic [WIDTH-1:0] tx_shift, tx_src;
  // Only WIDTH-1 bits are held here; the final bit goes straight into dataout.
  logic [WIDTH-2:0] rx_shift;
  logic [CW-1:0]    tcnt, tsum;
  logic             rx_prev, last_k, last_bit, frame_start;
  logic             tx_bit, fsk_nxt, decided;

  assign last_k      = (bit_cnt == CW'(BIT_CYCLES-1));
  assign last_bit    = (bit_idx == IW'(WIDTH-1));
  assign frame_start = (bit_idx == '0) && (bit_cnt == '0);

  // Next-state counters. fskdata is registered from these values, so the
  // output lines up with the counter value of the cycle it is shown in.
  always_comb begin
    cnt_nxt = bit_cnt + 1'b1;
    idx_nxt = bit_idx;
    if (last_k) begin
      cnt_nxt = '0;
      idx_nxt = last_bit ? '0 : bit_idx + 1'b1;
    end
  end

  // Bit source for the next cycle. On the load edge the new word is not in
  // tx_shift yet, so it is taken directly from datain.
  always_comb begin
    tx_src  = frame_start ? datain : tx_shift;
    tx_sel  = IW'(WIDTH-1) - idx_nxt;
    tx_bit  = tx_src[tx_sel];
    fsk_nxt = tx_bit ? ~cnt_nxt[1] : ~cnt_nxt[2];
  end

  // Transition count including this cycle. Window cycle 0 is the bit
  // boundary, and a change there belongs to the previous bit.
  always_comb begin
    tsum    = tcnt + CW'((bit_cnt != '0) && (rx_in != rx_prev));
    decided = (tsum >= CW'(THRESH));
  end

  // Counters and transmit path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      tx_shift <= '0;
      fskdata  <= 1'b0;
    end else begin
      bit_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      fskdata <= fsk_nxt;
      if (frame_start) tx_shift <= datain;
    end
  end

  // Receive path: count transitions, decide at the end of each window, and
  // publish the word on the last window of the frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_prev  <= 1'b0;
      tcnt     <= '0;
      rx_shift <= '0;
      dataout  <= '0;
    end else begin
      rx_prev <= rx_in;
      if (last_k) begin
        tcnt     <= '0;
        rx_shift <= {rx_shift[WIDTH-3:0], decided};
        if (last_bit) dataout <= {rx_shift, decided};
      end else begin
        tcnt <= tsum;
      end
    end
  end

`ifdef FSK_VALID_EN
  // One-cycle strobe that coincides with each dataout update.
  always_ff @(posedge clk) begin
    if (!reset) dout_valid <= 1'b0;
    else        dout_valid <= last_k && last_bit;
  end
`endif

endmodule

// File: tb/tb_fsk_modem.sv
// tb_fsk_modem: directed bench for fsk_modem covering reset, loopback frames,
// the datain capture window, independent rx_in threshold decisions and
// mid-frame reset. Define FSK_VALID_EN to also cover dout_valid.
module tb_fsk_modem;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] datain = 9'h155;
  logic       fskdata, rx_in;
  logic       rx_drv = 1'b0;
  logic       loop = 1'b1;
  logic [8:0] dataout;
  logic [15:0] pat1 = 16'hCCCC;   // '1' window, cycle 0 at bit 15
  logic [15:0] pat0 = 16'hF0F0;   // '0' window
  int nvec = 0;
  int nerr = 0;
`ifdef FSK_VALID_EN
  logic dout_valid;
  int   vcnt;
`endif

  assign rx_in = loop ? fskdata : rx_drv;

  always #5 clk = ~clk;

  fsk_modem dut (
    .clk     (clk),
    .reset   (reset),
    .datain  (datain),
    .fskdata (fskdata),
    .rx_in   (rx_in),
    .dataout (dataout)
`ifdef FSK_VALID_EN
    ,
    .dout_valid (dout_valid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame, starting in frame cycle 0. The bench drives datain there and
  // checks the waveform in cycles 1..143, then checks dataout after the final
  // edge. With loop=0, rx_in toggles in window cycles 1..n, where n is n1 or
  // n0 according to the matching bit of rxw.
  task automatic run_frame(input logic [8:0] word, input logic [8:0] rxw,
                           input int n1, input int n0, input int chg_at,
                           input logic [8:0] chg, input logic [8:0] exp_out,
                           input logic [8:0] prev_out);
    int k, b, n;
    logic e;
    datain = word;
`ifdef FSK_VALID_EN
    vcnt = 0;
`endif
    for (int j = 1; j <= 144; j++) begin
      tick();
`ifdef FSK_VALID_EN
      vcnt += int'(dout_valid);
`endif
      if (j < 144) begin
        k = j % 16;
        b = j / 16;
        e = word[8-b] ? pat1[15-k] : pat0[15-k];
        chk("fsk", {31'd0, fskdata}, {31'd0, e});
        if (j == 72) chk("hold", {23'd0, dataout}, {23'd0, prev_out});
        if (j == chg_at) datain = chg;
        n = rxw[8-b] ? n1 : n0;
        if (!loop && k >= 1 && k <= n) rx_drv = ~rx_drv;
      end
    end
    chk("dout", {23'd0, dataout}, {23'd0, exp_out});
`ifdef FSK_VALID_EN
    chk("vld_cnt", vcnt, 1);
    chk("vld_edge", {31'd0, dout_valid}, 32'd1);
`endif
  endtask

  initial begin
    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_fsk", {31'd0, fskdata}, 32'd0);
      chk("rst_dout", {23'd0, dataout}, 32'd0);
    end
    reset = 1'b1;

    // Loopback: all ones, all zeros, an incrementing run across the wrap,
    // then a datain change in mid-frame.
    run_frame(9'h1FF, 9'h0, 0, 0, -1, 9'h0, 9'h1FF, 9'h000);
    run_frame(9'h000, 9'h0, 0, 0, -1, 9'h0, 9'h000, 9'h1FF);
    run_frame(9'h1FE, 9'h0, 0, 0, -1, 9'h0, 9'h1FE, 9'h000);
    run_frame(9'h1FF, 9'h0, 0, 0, -1, 9'h0, 9'h1FF, 9'h1FE);
    run_frame(9'h000, 9'h0, 0, 0, -1, 9'h0, 9'h000, 9'h1FF);
    run_frame(9'h001, 9'h0, 0, 0, -1, 9'h0, 9'h001, 9'h000);
    run_frame(9'h0A5, 9'h0, 0, 0, 50, 9'h15A, 9'h0A5, 9'h001);

    // Independent rx_in: 5 transitions decide '1' and 4 decide '0';
    // then the extremes of 15 and 0 transitions.
    loop = 1'b0;
    rx_drv = 1'b0;
    run_frame(9'h12C, 9'h0B3, 5, 4, -1, 9'h0, 9'h0B3, 9'h0A5);
    run_frame(9'h12C, 9'h1C6, 15, 0, -1, 9'h0, 9'h1C6, 9'h0B3);
    loop = 1'b1;

    // Reset asserted mid-frame: the partial word is discarded and the next
    // frame realigns to the release.
    datain = 9'h0C3;
    for (int i = 0; i < 70; i++) tick();
    reset = 1'b0;
    tick();
    chk("mrst_fsk", {31'd0, fskdata}, 32'd0);
    chk("mrst_dout", {23'd0, dataout}, 32'd0);
    reset = 1'b1;
    run_frame(9'h0C3, 9'h0, 0, 0, -1, 9'h0, 9'h0C3, 9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fsk_modem.md
Name: fsk_modem

Overview:
- Single-clock binary FSK modem: serialises a 9-bit parallel word into a frequency-shift-keyed square wave (fskdata) and demodulates an FSK input (rx_in) back into a 9-bit word (dataout).
- The transmitter and receiver share bit/frame counters and are frame-aligned by reset.
- Used in loopback between a parallel data source and a sink; no start bit or preamble.

Parameters:
- WIDTH, 9, bits per frame (datain/dataout width).
- BIT_CYCLES, 16, clk cycles per transmitted bit.
- THRESH, 5, minimum transitions in a bit window for the receiver to decide '1'.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- datain  input  WIDTH  parallel word to transmit; sampled at frame start only.
- fskdata  output  1  FSK modulated serial output, registered.
- rx_in  input  1  FSK serial input (normally tied to fskdata).
- dataout  output  WIDTH  last demodulated word, registered.

Behaviour:
- Reset (reset==0 at a rising edge):
  - bit_cnt (0..BIT_CYCLES-1), bit_idx (0..WIDTH-1), tx_shift, rx_shift, transition counter and rx_prev all clear to 0.
  - fskdata=0, dataout=0.
- Counters:
  - bit_cnt increments every cycle and wraps 15->0.
  - On the wrap, bit_idx increments; it wraps 8->0.
  - One frame = WIDTH*BIT_CYCLES = 144 cycles.
  - The first cycle after reset release is frame cycle 0 (bit_idx=0, bit_cnt=0).
- TX load: at bit_idx=0, bit_cnt=0, datain is captured into tx_shift. datain changes at any other time are ignored for the current frame.
- TX order: MSB first; bit i of the frame is datain[WIDTH-1-i].
- TX waveform: in bit-window cycle k (the k-th cycle of the bit, with fskdata as seen after that cycle's edge):
  - bit '1': fskdata = ~k[1], pattern 1100 1100 1100 1100 (period 4).
  - bit '0': fskdata = ~k[2], pattern 11110000 11110000 (period 8).
  - fskdata has zero extra latency relative to the counters; it is computed from next-state counters and registered.
- RX sampling: rx_prev <= rx_in every cycle. A transition is rx_in != rx_prev.
  - Transitions are counted only in window cycles k=1..15; k=0 (bit boundary) is ignored.
  - Ideal counts: '1' = 7 transitions, '0' = 3 transitions.
  - At k=15, the decided bit (count incl. this cycle >= THRESH) is shifted into rx_shift LSB-side, MSB first. The counter then clears.
- RX output: at bit_idx=8, k=15 the completed word (rx_shift with the final bit) is written to dataout at the same edge. dataout holds for the next 144 cycles.
- Latency: word captured at frame cycle 0 appears on dataout at frame cycle 143 of the same frame (loopback, zero wire delay).
- Reset mid-frame: all state aborts immediately; the partial word is discarded and dataout returns to 0.
- Noisy input: a decision uses only the threshold compare; ties are impossible since THRESH is fixed.

Optional Feature:
- Macro FSK_VALID_EN.
- When defined: extra output port dout_valid (1 bit, reset 0). It pulses high for exactly one cycle on the edge where dataout is updated (every 144 cycles).
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles with datain=9'h155 -> fskdata=0, dataout=0 throughout; counters 0.
- Loopback, datain=9'h1FF constant -> fskdata period-4 pattern for 144 cycles; dataout=9'h1FF at cycle 143.
- Loopback, datain=9'h000 -> period-8 pattern; dataout=9'h000 at cycle 143.
- Loopback, datain incrementing 0,1,2,... each 144 cycles, wrapping 9'h1FF->0 -> each frame's dataout equals the word latched at that frame's cycle 0.
- datain changed mid-frame (cycle 50, 9'h0A5->9'h15A) -> transmitted/received word stays 9'h0A5.
- rx_in driven independently with 4 transitions in a bit window -> decided '0'; with 5 -> '1'; with FSK_VALID_EN, dout_valid pulses once per 144 cycles.
